dmem_arbiter: RTL and testbench

//  Shares the single-port 8-bit data memory between the CPU datapath (load/store path) and an

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/dmem_arb_starve_ctr.sv | 41 ++++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Purpose : Shared types and constants for the data-memory arbiter.
//           arb_state_t  - transaction sequencer states
//           owner_t      - which requester owns the in-flight access
//           STALL_CNT_W  - width of the optional stall-cycle counter
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int STALL_CNT_W = 16;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_starve_ctr
// Purpose : Saturating counter of consecutive arbitration rounds the host
//           has lost to the CPU.
// Ports   : clk    - clock, rising edge
//           rst    - asynchronous reset, active-low
//           inc    - host lost an arbitration round this cycle
//           clr    - host was granted this cycle
//           at_max - counter has reached MAX (host must win next round)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int            c_CNT_W = $clog2(MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX);

    logic [c_CNT_W-1:0] r_cnt;

    assign at_max = (r_cnt == c_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule : dmem_arb_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Shares a single-port data memory between the CPU load/store path
//           and a host loader/debug port. One transaction in flight at a
//           time (IDLE -> ISSUE -> WAIT -> RESP). CPU has priority; the host
//           is forced through after HOST_MAX_WAIT consecutive lost rounds.
// Ports   : clk, rst (async, active-low)
//           cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//           host_req/host_we/host_addr/host_wdata -> host_gnt, host_rvalid,
//             host_rdata
//           mem_addr/mem_wdata/mem_read/mem_write <- mem_rdata
//           stall_cycles (only with DMEM_ARB_STALL_CNT_EN defined)
// Config  : DMEM_ARB_STALL_CNT_EN - adds a saturating 16-bit count of cycles
//           in which cpu_stall was high.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int MEM_LAT       = 1,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    // Sized so MEM_LAT=1 still gets a 1-bit counter.
    localparam int                  c_WAIT_W    = $clog2(MEM_LAT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_LAT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata_q;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic w_host_win;
    logic w_cpu_win;
    logic w_capture;
    logic w_starve_max;
    logic w_starve_inc;

    // ------------------------------------------------------------------
    // Next-state and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_host_win  = 1'b0;
        w_cpu_win   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req && (!cpu_req || w_starve_max)) begin
                    w_host_win  = 1'b1;
                    w_state_nxt = ISSUE;
                end else if (cpu_req) begin
                    w_cpu_win   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Transaction latch, latency counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= OWN_CPU;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata_q  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_host_win) begin
                r_owner <= OWN_HOST;
                r_we    <= host_we;
                r_addr  <= host_addr;
                r_wdata <= host_wdata;
            end else if (w_cpu_win) begin
                r_owner <= OWN_CPU;
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end

            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == WAIT) && !w_capture) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end

            // Writes leave the previous read data untouched.
            if (w_capture && !r_we) begin
                r_rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking: the host loses whenever the CPU wins while the
    // host is also requesting.
    // ------------------------------------------------------------------
    assign w_starve_inc = (r_state == IDLE) && host_req && cpu_req && !w_starve_max;

    dmem_arb_starve_ctr #(
        .MAX    (HOST_MAX_WAIT)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_starve_inc),
        .clr    (w_host_win),
        .at_max (w_starve_max)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_read    = (r_state == ISSUE) && !r_we;
    assign mem_write   = (r_state == ISSUE) &&  r_we;
    assign host_gnt    = w_host_win;
    assign host_rvalid = (r_state == RESP) && (r_owner == OWN_HOST);
    assign host_rdata  = r_rdata_q;
    assign cpu_rdata   = r_rdata_q;
    assign cpu_stall   = cpu_req && !((r_state == RESP) && (r_owner == OWN_CPU));

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (cpu_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    // Host must hold its request until it is granted.
    a_host_req_held : assert property (
        @(posedge clk) disable iff (!rst)
        (host_req && !host_gnt) |=> host_req
    );

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Purpose : Self-checking bench for dmem_arbiter with a 1-cycle-latency
//           synchronous memory model and a scoreboard of expected load data.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MEM_LAT       = 1;
    localparam int HOST_MAX_WAIT = 4;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write;

    dmem_arbiter #(
        .ADDR_W        (8),
        .DATA_W        (8),
        .MEM_LAT       (MEM_LAT),
        .HOST_MAX_WAIT (HOST_MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        if (i == 16) return 8'hA5;
        return 8'(i * 7 + 3);
    endfunction

    // Memory model: strobe sampled on a rising edge, data valid next cycle.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= pat(i);
            ref_mem[i]  = pat(i);
        end
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata     <= mem[mem_addr];
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t cpu_q[$];
    exp_t host_q[$];

    int         n_rd = 0, n_wr = 0, n_rv = 0;
    logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
            end
            if (host_rvalid) n_rv++;
            if (cpu_req && !cpu_stall) begin
                if (cpu_q.size() == 0) check_val("cpu_unexpected_done", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    if (!e.we) check_val("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.data});
                end
            end
            if (host_rvalid) begin
                if (host_q.size() == 0) check_val("host_unexpected_rvalid", 1, 0);
                else begin
                    e = host_q.pop_front();
                    if (!e.we) check_val("host_rdata", {24'h0, host_rdata}, {24'h0, e.data});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic cpu_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                              output int stall_cyc);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        cpu_q.push_back({we, we ? d : ref_mem[a]});
        if (we) ref_mem[a] = d;
        stall_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cpu_stall) break;
            stall_cyc++;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    // CPU issues cpu_n back-to-back loads of caddr (request held) while the
    // host makes one request; cycle numbers count from the request cycle.
    task automatic run_mixed(input int cpu_n, input logic [7:0] caddr,
                             input logic hwe, input logic [7:0] haddr, input logic [7:0] hwd,
                             output int gnt_cyc, output int rv_cyc, output int cdone_gnt,
                             output logic done);
        int cdone;
        @(posedge clk); #1;
        cpu_req  = (cpu_n > 0); cpu_we = 1'b0; cpu_addr = caddr;
        host_req = 1'b1; host_we = hwe; host_addr = haddr; host_wdata = hwd;
        for (int k = 0; k < cpu_n; k++) cpu_q.push_back({1'b0, ref_mem[caddr]});
        host_q.push_back({hwe, hwe ? hwd : ref_mem[haddr]});
        if (hwe) ref_mem[haddr] = hwd;
        cdone = 0; gnt_cyc = -1; rv_cyc = -1; cdone_gnt = -1; done = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (cpu_req && !cpu_stall) cdone++;
            if (host_gnt && gnt_cyc < 0) begin
                gnt_cyc   = cyc;
                cdone_gnt = cdone;
            end
            if (host_rvalid && rv_cyc < 0) rv_cyc = cyc;
            if (rv_cyc >= 0 && cdone >= cpu_n) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (gnt_cyc >= 0) host_req = 1'b0;
            if (cdone >= cpu_n) cpu_req = 1'b0;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; host_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int   st, g, r, cg, rd0, wr0, rv0;
        logic dn;

        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;

        repeat (2) @(posedge clk); #1;
        check_val("rst_stall_noreq", {31'h0, cpu_stall}, 0);
        cpu_req = 1'b1; #1;
        check_val("rst_stall_req", {31'h0, cpu_stall}, 1);
        cpu_req = 1'b0; #1;
        check_val("rst_mem_read",  {31'h0, mem_read}, 0);
        check_val("rst_mem_write", {31'h0, mem_write}, 0);
        check_val("rst_host_gnt",  {31'h0, host_gnt}, 0);
        check_val("rst_rvalid",    {31'h0, host_rvalid}, 0);
        check_val("rst_mem_addr",  {24'h0, mem_addr}, 0);
        check_val("rst_mem_wdata", {24'h0, mem_wdata}, 0);
        check_val("rst_host_rdata",{24'h0, host_rdata}, 0);
        check_val("rst_cpu_rdata", {24'h0, cpu_rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // CPU load 0x10 -> 0xA5, three stall cycles, one read strobe
        rd0 = n_rd;
        cpu_access(1'b0, 8'h10, 8'h00, st);
        check_val("load_stall_cycles", st, MEM_LAT + 2);
        check_val("load_read_strobes", n_rd - rd0, 1);

        // CPU store 0x3C to 0x20, then read it back
        wr0 = n_wr; rd0 = n_rd;
        cpu_access(1'b1, 8'h20, 8'h3C, st);
        check_val("store_stall_cycles", st, MEM_LAT + 2);
        check_val("store_write_strobes", n_wr - wr0, 1);
        check_val("store_read_strobes", n_rd - rd0, 0);
        check_val("store_addr", {24'h0, last_waddr}, 32'h20);
        check_val("store_wdata", {24'h0, last_wdata}, 32'h3C);
        cpu_access(1'b0, 8'h20, 8'h00, st);
        check_val("reload_stall_cycles", st, MEM_LAT + 2);

        // Host read 0x05 with CPU idle
        run_mixed(0, 8'h00, 1'b0, 8'h05, 8'h00, g, r, cg, dn);
        check_val("hrd_done", {31'h0, dn}, 1);
        check_val("hrd_gnt_cycle", g, 0);
        check_val("hrd_rvalid_lat", r - g, MEM_LAT + 2);

        // Host write 0x77 to 0x30, CPU reads it back
        wr0 = n_wr;
        run_mixed(0, 8'h00, 1'b1, 8'h30, 8'h77, g, r, cg, dn);
        check_val("hwr_done", {31'h0, dn}, 1);
        check_val("hwr_gnt_cycle", g, 0);
        check_val("hwr_write_strobes", n_wr - wr0, 1);
        cpu_access(1'b0, 8'h30, 8'h00, st);
        check_val("hwr_reload_stall", st, MEM_LAT + 2);

        // CPU request held continuously: host forced through after max losses
        rd0 = n_rd;
        run_mixed(5, 8'h10, 1'b0, 8'h05, 8'h00, g, r, cg, dn);
        check_val("starve_done", {31'h0, dn}, 1);
        check_val("starve_gnt_cycle", g, HOST_MAX_WAIT * (MEM_LAT + 3));
        check_val("starve_cpu_before_gnt", cg, HOST_MAX_WAIT);
        check_val("starve_rvalid_lat", r - g, MEM_LAT + 2);
        check_val("starve_read_strobes", n_rd - rd0, 6);

        // Simultaneous single requests with empty starvation count: CPU first
        run_mixed(1, 8'h20, 1'b0, 8'h30, 8'h00, g, r, cg, dn);
        check_val("tie_done", {31'h0, dn}, 1);
        check_val("tie_gnt_cycle", g, MEM_LAT + 3);
        check_val("tie_cpu_before_gnt", cg, 1);

        // Reset while a host read sits in WAIT
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        @(negedge clk);
        check_val("abort_gnt", {31'h0, host_gnt}, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        check_val("abort_pre_addr", {24'h0, mem_addr}, 32'h05);
        rv0 = n_rv;
        rst = 1'b0; #1;
        check_val("abort_mem_addr",   {24'h0, mem_addr}, 0);
        check_val("abort_host_rdata", {24'h0, host_rdata}, 0);
        check_val("abort_cpu_rdata",  {24'h0, cpu_rdata}, 0);
        check_val("abort_rvalid",     {31'h0, host_rvalid}, 0);
        check_val("abort_mem_read",   {31'h0, mem_read}, 0);
        check_val("abort_stall",      {31'h0, cpu_stall}, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        check_val("abort_no_rvalid", n_rv - rv0, 0);
        cpu_access(1'b0, 8'h20, 8'h00, st);
        check_val("post_rst_stall", st, MEM_LAT + 2);

        repeat (3) @(posedge clk);
        check_val("cpu_queue_empty", cpu_q.size(), 0);
        check_val("host_queue_empty", host_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
